bp_cfg_csr_bank: RTL and testbench

Runtime configuration register bank that is the programmable successor to the static per-configuration processor parameter set. It holds reg_els_p registers for each of num_core_p cores and is written and read through a single-outstanding valid/ready request port with a buffered response. Per-core freeze and lock controls are decoded from register 0. The flattened register contents drive core-side configuration inputs such as hart id, cache mode and DRAM base.

---
 rtl/bp_cfg_csr_bank.sv | 142 ++++++++++++++
 tb/tb_bp_cfg_csr_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_csr_bank.sv
// Runtime configuration register bank: num_core_p copies of reg_els_p registers, byte-masked writes,
// per-core freeze (reg0 bit0) and sticky lock (reg0 bit1).
// Single outstanding request; the response is registered and held until resp_yumi_i.
module bp_cfg_csr_bank #(
  parameter int num_core_p = 4,
  parameter int reg_els_p = 8,
  parameter int reg_width_p = 64,
  parameter logic [reg_els_p*reg_width_p-1:0] reset_val_p = '0,
  parameter logic freeze_reset_p = 1'b1,
  localparam int lg_core_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1,
  localparam int lg_reg_lp = (reg_els_p > 1) ? $clog2(reg_els_p) : 1,
  localparam int mask_width_lp = reg_width_p / 8
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic                                        cfg_v_i,
  output logic                                        cfg_ready_o,
  input  logic                                        cfg_w_i,
  input  logic                                        cfg_bcast_i,
  input  logic [lg_core_lp-1:0]                       cfg_core_i,
  input  logic [lg_reg_lp-1:0]                        cfg_addr_i,
  input  logic [reg_width_p-1:0]                      cfg_data_i,
  input  logic [mask_width_lp-1:0]                    cfg_mask_i,
  output logic                                        resp_v_o,
  input  logic                                        resp_yumi_i,
  output logic [reg_width_p-1:0]                      resp_data_o,
  output logic                                        resp_err_o,
  output logic [num_core_p*reg_els_p*reg_width_p-1:0] cfg_regs_o,
  output logic [num_core_p-1:0]                       freeze_o,
  output logic [num_core_p-1:0]                       lock_o
);

  typedef enum logic {e_ready, e_resp} state_e;

  // One extra bit so the element counts themselves are representable for range checks.
  localparam logic [lg_reg_lp:0]  reg_els_lp  = (lg_reg_lp+1)'(reg_els_p);
  localparam logic [lg_core_lp:0] num_core_lp = (lg_core_lp+1)'(num_core_p);

  state_e state_q, state_d;
  logic [reg_width_p-1:0] regs_q [num_core_p][reg_els_p];
  logic [reg_width_p-1:0] regs_d [num_core_p][reg_els_p];
  logic [reg_width_p-1:0] resp_data_q;
  logic                   resp_err_q;

  logic                   accept;
  logic                   addr_bad, core_bad, tgt_locked, hard_err, skip;
  logic [reg_width_p-1:0] rd_data;

  function automatic logic [reg_width_p-1:0] merge_bytes(input logic [reg_width_p-1:0] old_val,
                                                          input logic [reg_width_p-1:0] new_val,
                                                          input logic [mask_width_lp-1:0] mask);
    merge_bytes = old_val;
    for (int b = 0; b < mask_width_lp; b++) begin
      if (mask[b]) merge_bytes[b*8 +: 8] = new_val[b*8 +: 8];
    end
  endfunction

  // Request decode: range checks, addressed-core lock and read data (taken before any write).
  always_comb begin
    accept     = (state_q == e_ready) && cfg_v_i && !reset_i;
    addr_bad   = ({1'b0, cfg_addr_i} >= reg_els_lp);
    core_bad   = !cfg_bcast_i && ({1'b0, cfg_core_i} >= num_core_lp);
    tgt_locked = 1'b0;
    rd_data    = '0;
    for (int c = 0; c < num_core_p; c++) begin
      if (cfg_core_i == lg_core_lp'(c)) begin
        tgt_locked = regs_q[c][0][1];
        for (int r = 0; r < reg_els_p; r++) begin
          if (cfg_addr_i == lg_reg_lp'(r)) rd_data = regs_q[c][r];
        end
      end
    end
    // Hard errors leave every register untouched; a broadcast skipping locked cores is not one.
    hard_err = addr_bad || core_bad || (cfg_bcast_i && !cfg_w_i)
            || (cfg_w_i && !cfg_bcast_i && (cfg_addr_i != '0) && tgt_locked);
  end

  // Register write: byte merge per targeted core; locked cores only accept reg0, lock bit is sticky.
  always_comb begin
    regs_d = regs_q;
    skip   = 1'b0;
    for (int c = 0; c < num_core_p; c++) begin
      for (int r = 0; r < reg_els_p; r++) begin
        if (accept && cfg_w_i && !hard_err && (cfg_addr_i == lg_reg_lp'(r))
            && (cfg_bcast_i || (cfg_core_i == lg_core_lp'(c)))) begin
          if ((r != 0) && regs_q[c][0][1]) begin
            skip = 1'b1;
          end else begin
            regs_d[c][r] = merge_bytes(regs_q[c][r], cfg_data_i, cfg_mask_i);
            if (r == 0) regs_d[c][0][1] = regs_d[c][0][1] | regs_q[c][0][1];
          end
        end
      end
    end
  end

  // Handshake FSM: accept in e_ready, hold the response in e_resp until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_ready: if (accept) state_d = e_resp;
      e_resp:  if (resp_yumi_i) state_d = e_ready;
      default: state_d = e_ready;
    endcase
  end

  // State, register file and response latch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_ready;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      for (int c = 0; c < num_core_p; c++) begin
        for (int r = 0; r < reg_els_p; r++) begin
          regs_q[c][r] <= reset_val_p[r*reg_width_p +: reg_width_p];
        end
        regs_q[c][0][0] <= freeze_reset_p;
      end
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      if (accept) begin
        resp_err_q  <= hard_err || skip;
        resp_data_q <= (hard_err || cfg_w_i) ? '0 : rd_data;
      end
    end
  end

  assign cfg_ready_o = (state_q == e_ready) && !reset_i;
  assign resp_v_o    = (state_q == e_resp) && !reset_i;
  assign resp_data_o = reset_i ? '0 : resp_data_q;
  assign resp_err_o  = reset_i ? 1'b0 : resp_err_q;

  for (genvar gc = 0; gc < num_core_p; gc++) begin : g_core
    assign freeze_o[gc] = regs_q[gc][0][0];
    assign lock_o[gc]   = regs_q[gc][0][1];
    for (genvar gr = 0; gr < reg_els_p; gr++) begin : g_reg
      assign cfg_regs_o[(gc*reg_els_p+gr)*reg_width_p +: reg_width_p] = regs_q[gc][gr];
    end
  end

endmodule

// File: tb/tb_bp_cfg_csr_bank.sv
// Randomised + directed bench with a response scoreboard; 5 cores so that an out-of-range
// core select is encodable, 6 registers so that addresses 6 and 7 are out of range.
module tb_bp_cfg_csr_bank;
  localparam int CORES = 5;
  localparam int REGS  = 6;
  localparam int W     = 64;
  localparam logic [REGS*W-1:0] RV = (REGS*W)'(64'h8000_0000) << (2*W);

  typedef struct packed {logic [63:0] data; logic err;} rsp_t;

  logic clk_i = 0, reset_i = 1;
  logic cfg_v_i = 0, cfg_w_i = 0, cfg_bcast_i = 0, resp_yumi_i;
  logic [2:0] cfg_core_i = 0, cfg_addr_i = 0;
  logic [63:0] cfg_data_i = 0;
  logic [7:0] cfg_mask_i = 0;
  logic cfg_ready_o, resp_v_o, resp_err_o;
  logic [63:0] resp_data_o;
  logic [CORES*REGS*W-1:0] cfg_regs_o;
  logic [CORES-1:0] freeze_o, lock_o;

  bp_cfg_csr_bank #(.num_core_p(CORES), .reg_els_p(REGS), .reg_width_p(W),
                    .reset_val_p(RV), .freeze_reset_p(1'b1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .cfg_v_i(cfg_v_i), .cfg_ready_o(cfg_ready_o),
    .cfg_w_i(cfg_w_i), .cfg_bcast_i(cfg_bcast_i), .cfg_core_i(cfg_core_i),
    .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i), .cfg_mask_i(cfg_mask_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_data_o(resp_data_o),
    .resp_err_o(resp_err_o), .cfg_regs_o(cfg_regs_o), .freeze_o(freeze_o), .lock_o(lock_o));

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;
  rsp_t exp_q[$];
  bit hold_yumi = 0;
  logic [63:0] model [CORES][REGS];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  function automatic logic [63:0] dut_reg(input int c, input int r);
    return cfg_regs_o[(c*REGS+r)*W +: W];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CORES; c++)
      for (int r = 0; r < REGS; r++)
        model[c][r] = (r == 2) ? 64'h8000_0000 : ((r == 0) ? 64'h1 : 64'h0);
  endtask

  // Spec-level write: byte mask expanded into a bit mask; lock bit can only go 0->1.
  function automatic logic [63:0] apply(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m, input int r);
    logic [63:0] bm, nv;
    for (int b = 0; b < 8; b++) bm[b*8 +: 8] = m[b] ? 8'hFF : 8'h00;
    nv = (old & ~bm) | (d & bm);
    if (r == 0) nv[1] = nv[1] | old[1];
    return nv;
  endfunction

  task automatic model_req(input bit w, input bit bc, input int core, input int addr,
                           input logic [63:0] d, input logic [7:0] m, output rsp_t e);
    e = '0;
    if (addr >= REGS || (!bc && core >= CORES) || (bc && !w)) e.err = 1;
    else if (!w) e.data = model[core][addr];
    else if (!bc) begin
      if (addr != 0 && model[core][0][1]) e.err = 1;
      else model[core][addr] = apply(model[core][addr], d, m, addr);
    end else begin
      for (int c = 0; c < CORES; c++) begin
        if (addr != 0 && model[c][0][1]) e.err = 1;
        else model[c][addr] = apply(model[c][addr], d, m, addr);
      end
    end
  endtask

  task automatic issue(input bit w, input bit bc, input int core, input int addr,
                       input logic [63:0] d, input logic [7:0] m);
    rsp_t e;
    int n = 0;
    @(negedge clk_i);
    while (!cfg_ready_o && n < 100) begin @(negedge clk_i); n++; end
    if (!cfg_ready_o) begin chk("ready_wait", cfg_ready_o, 1); return; end
    model_req(w, bc, core, addr, d, m, e);
    exp_q.push_back(e);
    cfg_v_i = 1; cfg_w_i = w; cfg_bcast_i = bc; cfg_core_i = 3'(core);
    cfg_addr_i = 3'(addr); cfg_data_i = d; cfg_mask_i = m;
    @(negedge clk_i);
    cfg_v_i = 0;
    chk("resp_latency", resp_v_o, 1);
  endtask

  task automatic drain();
    int n = 0;
    do begin @(negedge clk_i); n++; end
    while ((exp_q.size() != 0 || !cfg_ready_o) && n < 200);
    chk("drain_ready", cfg_ready_o, 1);
  endtask

  task automatic check_state();
    logic [CORES-1:0] ef, el;
    for (int c = 0; c < CORES; c++) begin
      ef[c] = model[c][0][0];
      el[c] = model[c][0][1];
      for (int r = 0; r < REGS; r++) chk($sformatf("reg_c%0d_r%0d", c, r), dut_reg(c, r), model[c][r]);
    end
    chk("freeze_o", 64'(freeze_o), 64'(ef));
    chk("lock_o", 64'(lock_o), 64'(el));
  endtask

  // Monitor: pops one expectation per response, then checks it stays stable until consumed.
  initial begin : monitor
    bit have = 0;
    rsp_t cur;
    resp_yumi_i = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        have = 0; resp_yumi_i = 0; exp_q.delete();
      end else begin
        if (resp_yumi_i && have) have = 0;
        resp_yumi_i = 0;
        if (resp_v_o) begin
          if (!have) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_resp", resp_v_o, 0);
              resp_yumi_i = 1;
            end else begin
              cur = exp_q.pop_front();
              have = 1;
              chk("resp_data", resp_data_o, cur.data);
              chk("resp_err", resp_err_o, cur.err);
            end
          end else begin
            chk("hold_data", resp_data_o, cur.data);
            chk("hold_err", resp_err_o, cur.err);
          end
          if (have) resp_yumi_i = hold_yumi ? 0 : ($urandom_range(0, 2) == 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int core, addr;
    logic [63:0] d;
    model_reset();
    repeat (3) @(negedge clk_i);
    chk("ready_in_reset", cfg_ready_o, 0);
    chk("resp_v_in_reset", resp_v_o, 0);
    reset_i = 0;
    @(negedge clk_i);
    chk("ready_after_reset", cfg_ready_o, 1);
    chk("freeze_reset", 64'(freeze_o), 64'h1F);
    chk("lock_reset", 64'(lock_o), 64'h0);
    check_state();

    // Reset-image read.
    issue(0, 0, 1, 2, 0, 0);
    drain();

    // Masked write, then a read held for five cycles.
    issue(1, 0, 2, 3, 64'h1122334455667788, 8'b0000_0011);
    drain();
    chk("masked_write", dut_reg(2, 3), 64'h7788);
    hold_yumi = 1;
    issue(0, 0, 2, 3, 0, 0);
    repeat (5) begin
      @(negedge clk_i);
      chk("stall_resp_v", resp_v_o, 1);
      chk("stall_ready", cfg_ready_o, 0);
    end
    hold_yumi = 0;
    drain();

    // Broadcast with core1 locked; broadcast read.
    issue(1, 0, 1, 0, 64'h2, 8'h01);
    drain();
    chk("core1_locked", 64'(lock_o), 64'h02);
    issue(1, 1, 0, 4, 64'hAB, 8'h01);
    drain();
    chk("bcast_core0", dut_reg(0, 4), 64'hAB);
    chk("bcast_core1_skip", dut_reg(1, 4), 64'h0);
    chk("bcast_core3", dut_reg(3, 4), 64'hAB);
    for (int c = 0; c < CORES; c++) issue(0, 0, c, 4, 0, 0);
    issue(0, 1, 0, 4, 0, 0);
    drain();

    // Lock stickiness on core0.
    issue(1, 0, 0, 0, 64'h2, 8'hFF);
    drain();
    chk("lock_set", 64'(lock_o), 64'h03);
    issue(1, 0, 0, 0, 64'h0, 8'hFF);
    drain();
    chk("lock_sticky", 64'(lock_o), 64'h03);
    issue(1, 0, 0, 1, 64'hDEAD, 8'hFF);
    issue(1, 0, 2, 0, 64'h0, 8'h00);
    drain();
    chk("locked_reg1", dut_reg(0, 1), 64'h0);

    // Out-of-range address and core.
    issue(0, 0, 0, 7, 0, 0);
    issue(1, 0, 3, 6, 64'hFFFF, 8'hFF);
    issue(1, 0, 5, 1, 64'hFFFF, 8'hFF);
    issue(0, 0, 7, 1, 0, 0);
    drain();
    check_state();

    // Randomised traffic.
    for (int i = 0; i < 250; i++) begin
      core = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      addr = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
      d = {$urandom, $urandom};
      if (addr == 0) d[1] = ($urandom_range(0, 9) == 0);
      issue($urandom_range(0, 1), $urandom_range(0, 5) == 0, core, addr, d, 8'($urandom));
      if (i % 50 == 49) begin drain(); check_state(); end
    end
    drain();

    // Reset while a response is pending.
    hold_yumi = 1;
    issue(0, 0, 3, 4, 0, 0);
    reset_i = 1;
    @(negedge clk_i);
    chk("resp_v_after_reset", resp_v_o, 0);
    @(negedge clk_i);
    model_reset();
    hold_yumi = 0;
    reset_i = 0;
    @(negedge clk_i);
    chk("ready_after_midreset", cfg_ready_o, 1);
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
